// File: rtl/module_link_receiver.sv
// module_link_receiver
//   Receives 4-byte frames (A5, STATUS, TEMP, CSUM) from greenhouse module 1 over an
//   8N1 UART line. It validates the checksum, converts TEMP from binary to packed BCD
//   and reports link health.
//
// Ports
//   CLOCK_50       in   sole clock, posedge
//   RESET          in   synchronous, active-high
//   RX             in   asynchronous serial input, idle high, LSB first
//   TEMP_F         out  packed BCD {hundreds[1:0], tens[3:0], ones[3:0]}
//   MODULE1_STATUS out  STATUS[3:0] of the last good frame
//   FRAME_VALID    out  one-cycle pulse when TEMP_F / MODULE1_STATUS update
//   FRAME_ERR      out  one-cycle pulse on a rejected frame
//   ERR_COUNT      out  saturating count of rejected frames
//   LINK_OK        out  high while good frames arrive within STALE_CLKS
module module_link_receiver #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_CLKS = 50000,
    parameter int unsigned STALE_CLKS   = 100000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       RX,
    output logic [9:0] TEMP_F,
    output logic [3:0] MODULE1_STATUS,
    output logic       FRAME_VALID,
    output logic       FRAME_ERR,
    output logic [7:0] ERR_COUNT,
    output logic       LINK_OK
);
    localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
    localparam int unsigned BitW    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned ToW     = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned StW     = $clog2(STALE_CLKS + 1);
    localparam logic [7:0]  Header  = 8'hA5;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {PsHdr, PsStat, PsTemp, PsCsum, PsConv} ps_state_e;

    logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_stb_q, byte_stb_d, frm_err_q, frm_err_d;

    ps_state_e       ps_state_q, ps_state_d;
    logic [7:0]      stat_byte_q, stat_byte_d, temp_byte_q, temp_byte_d;
    logic [ToW-1:0]  timer_q, timer_d;
    logic [7:0]      bin_q, bin_d;
    logic [9:0]      bcd_q, bcd_d, bcd_adj;
    logic [3:0]      dd_cnt_q, dd_cnt_d;

    logic [9:0]      temp_f_q, temp_f_d;
    logic [3:0]      status_q, status_d;
    logic            frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [StW-1:0]  stale_q, stale_d;
    logic            link_ok_q, link_ok_d;

    // Bit receiver: all sampling points are offsets from the start-bit midpoint.
    always_comb begin
        rx_meta_d  = RX;
        rx_sync_d  = rx_meta_q;
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_stb_d = 1'b0;
        frm_err_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    bit_cnt_d  = '0;
                end
            end
            RxStart: begin
                if (bit_cnt_q == BitW'(HalfBit - 1)) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    // Line back high at the midpoint: a glitch, not a start bit.
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (bit_cnt_q == BitW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RxStop;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (bit_cnt_q == BitW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_d  = '0;
                    rx_state_d = RxIdle;
                    byte_stb_d = rx_sync_q;
                    frm_err_d  = !rx_sync_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // Frame parser, double-dabble converter and output registers.
    always_comb begin
        ps_state_d    = ps_state_q;
        stat_byte_d   = stat_byte_q;
        temp_byte_d   = temp_byte_q;
        timer_d       = timer_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        dd_cnt_d      = dd_cnt_q;
        temp_f_d      = temp_f_q;
        status_d      = status_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        bcd_adj       = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

        // Bytes and framing errors arriving during conversion are dropped.
        if (frm_err_q && ps_state_q != PsConv) begin
            frame_err_d = 1'b1;
            ps_state_d  = PsHdr;
            timer_d     = '0;
        end else begin
            unique case (ps_state_q)
                PsHdr: begin
                    timer_d = '0;
                    if (byte_stb_q && shift_q == Header) ps_state_d = PsStat;
                end
                PsStat, PsTemp, PsCsum: begin
                    timer_d = timer_q + 1'b1;
                    if (byte_stb_q) begin
                        timer_d = '0;
                        if (ps_state_q == PsStat) begin
                            stat_byte_d = shift_q;
                            ps_state_d  = PsTemp;
                        end else if (ps_state_q == PsTemp) begin
                            temp_byte_d = shift_q;
                            ps_state_d  = PsCsum;
                        end else if (shift_q == (Header ^ stat_byte_q ^ temp_byte_q)) begin
                            // First shift happens on the load so the result lands 9 cycles
                            // after the checksum strobe.
                            bin_d      = {temp_byte_q[6:0], 1'b0};
                            bcd_d      = {9'd0, temp_byte_q[7]};
                            dd_cnt_d   = 4'd1;
                            ps_state_d = PsConv;
                        end else begin
                            frame_err_d = 1'b1;
                            ps_state_d  = PsHdr;
                        end
                    end else if (timer_q == ToW'(TIMEOUT_CLKS - 1)) begin
                        frame_err_d = 1'b1;
                        ps_state_d  = PsHdr;
                        timer_d     = '0;
                    end
                end
                PsConv: begin
                    if (dd_cnt_q == 4'd8) begin
                        temp_f_d      = bcd_q;
                        status_d      = stat_byte_q[3:0];
                        frame_valid_d = 1'b1;
                        ps_state_d    = PsHdr;
                    end else begin
                        bcd_d    = {bcd_adj[8:0], bin_q[7]};
                        bin_d    = {bin_q[6:0], 1'b0};
                        dd_cnt_d = dd_cnt_q + 4'd1;
                    end
                end
                default: ps_state_d = PsHdr;
            endcase
        end

        err_count_d = err_count_q;
        if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;

        stale_d   = stale_q;
        link_ok_d = link_ok_q;
        if (frame_valid_d) begin
            stale_d   = '0;
            link_ok_d = 1'b1;
        end else begin
            if (stale_q != StW'(STALE_CLKS)) stale_d = stale_q + 1'b1;
            if (stale_d == StW'(STALE_CLKS)) link_ok_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RxIdle;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_stb_q    <= 1'b0;
            frm_err_q     <= 1'b0;
            ps_state_q    <= PsHdr;
            stat_byte_q   <= '0;
            temp_byte_q   <= '0;
            timer_q       <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            dd_cnt_q      <= '0;
            temp_f_q      <= '0;
            status_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
            stale_q       <= '0;
            link_ok_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_stb_q    <= byte_stb_d;
            frm_err_q     <= frm_err_d;
            ps_state_q    <= ps_state_d;
            stat_byte_q   <= stat_byte_d;
            temp_byte_q   <= temp_byte_d;
            timer_q       <= timer_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            dd_cnt_q      <= dd_cnt_d;
            temp_f_q      <= temp_f_d;
            status_q      <= status_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
            stale_q       <= stale_d;
            link_ok_q     <= link_ok_d;
        end
    end

    assign TEMP_F         = temp_f_q;
    assign MODULE1_STATUS = status_q;
    assign FRAME_VALID    = frame_valid_q;
    assign FRAME_ERR      = frame_err_q;
    assign ERR_COUNT      = err_count_q;
    assign LINK_OK        = link_ok_q;

endmodule

// File: tb/tb_module_link_receiver.sv
// tb_module_link_receiver
//   Drives UART frames into module_link_receiver and checks every output every cycle
//   against a byte-level frame model plus literal expectations for known frames.
module tb_module_link_receiver;
    localparam int unsigned Cpb   = 8;
    localparam int unsigned Tmo   = 200;
    localparam int unsigned Stale = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [9:0] temp_f;
    logic [3:0] status;
    logic       frame_valid;
    logic       frame_err;
    logic [7:0] err_count;
    logic       link_ok;

    always #5 clk = ~clk;

    module_link_receiver #(
        .CLKS_PER_BIT(Cpb),
        .TIMEOUT_CLKS(Tmo),
        .STALE_CLKS  (Stale)
    ) dut (
        .CLOCK_50      (clk),
        .RESET         (rst),
        .RX            (rx),
        .TEMP_F        (temp_f),
        .MODULE1_STATUS(status),
        .FRAME_VALID   (frame_valid),
        .FRAME_ERR     (frame_err),
        .ERR_COUNT     (err_count),
        .LINK_OK       (link_ok)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [9:0] temp;
        logic [3:0] stat;
    } ev_t;
    ev_t exp_q[$];

    // Byte-level frame model state (driver side).
    int         pstate = 0;
    logic [7:0] p_stat, p_temp;

    // Output model state (compare side).
    logic [9:0] m_temp = '0;
    logic [3:0] m_stat = '0;
    int         m_err  = 0;
    int         since  = 0;
    bit         seen   = 0;

    logic [7:0] r_st, r_tp, r_cs;
    bit         got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] to_bcd(input int unsigned t);
        return {2'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        case (pstate)
            0: if (b == 8'hA5) pstate = 1;
            1: begin p_stat = b; pstate = 2; end
            2: begin p_temp = b; pstate = 3; end
            default: begin
                e.is_err = (b != (8'hA5 ^ p_stat ^ p_temp));
                e.temp   = to_bcd(int'(p_temp));
                e.stat   = p_stat[3:0];
                exp_q.push_back(e);
                pstate = 0;
            end
        endcase
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.temp   = '0;
        e.stat   = '0;
        exp_q.push_back(e);
        pstate = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(Cpb);
        end
        rx = stop;
        tick(Cpb);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] t, input logic [7:0] c);
        send(8'hA5);
        send(s);
        send(t);
        send(c);
    endtask

    task automatic wait_pulse(input bit want_err, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (want_err ? frame_err : frame_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        bit   rst_at;
        ev_t  e;
        forever begin
            @(posedge clk);
            rst_at = rst;
            @(negedge clk);
            if (rst_at) begin
                m_temp = '0;
                m_stat = '0;
                m_err  = 0;
                since  = 0;
                seen   = 0;
                exp_q.delete();
                check("rst_temp_f", 32'(temp_f), 32'h0);
                check("rst_status", 32'(status), 32'h0);
                check("rst_pulses", 32'({frame_valid, frame_err}), 32'h0);
                check("rst_err_count", 32'(err_count), 32'h0);
                check("rst_link_ok", 32'(link_ok), 32'h0);
            end else begin
                check("exclusive", 32'(frame_valid & frame_err), 32'h0);
                if (frame_valid || frame_err) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: valid=%0b err=%0b with no frame due at %0t",
                                 frame_valid, frame_err, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                        if (!e.is_err) begin
                            m_temp = e.temp;
                            m_stat = e.stat;
                            seen   = 1;
                            since  = 0;
                        end else if (m_err < 255) begin
                            m_err++;
                        end
                    end
                end else if (seen && since < 1000000) begin
                    since++;
                end
                check("temp_f", 32'(temp_f), 32'(m_temp));
                check("status", 32'(status), 32'(m_stat));
                check("err_count", 32'(err_count), 32'(m_err));
                check("link_ok", 32'(link_ok), 32'(seen && since < int'(Stale)));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        check("lit_reset_temp", 32'(temp_f), 32'h0);
        check("lit_reset_link", 32'(link_ok), 32'h0);
        rst    = 1'b0;
        pstate = 0;
        tick(20);

        // Known frames.
        send_frame(8'h03, 8'h48, 8'hEE);
        wait_pulse(1'b0, got);
        check("lit_f1_seen", 32'(got), 32'h1);
        check("lit_f1_temp", 32'(temp_f), 32'h072);
        check("lit_f1_status", 32'(status), 32'h3);
        check("lit_f1_link", 32'(link_ok), 32'h1);
        tick(20);
        send_frame(8'h01, 8'hFF, 8'h5B);
        wait_pulse(1'b0, got);
        check("lit_f2_temp", 32'(temp_f), 32'h255);
        check("lit_f2_status", 32'(status), 32'h1);
        tick(20);
        send_frame(8'h00, 8'h00, 8'hA5);
        wait_pulse(1'b0, got);
        check("lit_f3_temp", 32'(temp_f), 32'h000);
        tick(20);

        // Bad checksum holds outputs.
        send_frame(8'h03, 8'h48, 8'h00);
        wait_pulse(1'b1, got);
        check("lit_csum_err_seen", 32'(got), 32'h1);
        check("lit_csum_err_count", 32'(err_count), 32'h1);
        check("lit_csum_hold_temp", 32'(temp_f), 32'h000);
        check("lit_csum_hold_status", 32'(status), 32'h0);
        tick(20);

        // Short glitch mid-frame must not create a byte.
        send(8'hA5);
        rx = 1'b0;
        tick(Cpb / 4);
        rx = 1'b1;
        tick(Cpb * 2);
        send(8'h03);
        send(8'h48);
        send(8'hEE);
        wait_pulse(1'b0, got);
        check("lit_glitch_temp", 32'(temp_f), 32'h072);
        tick(20);

        // Bad stop bit, then recovery.
        push_err();
        send_byte(8'h3C, 1'b0);
        wait_pulse(1'b1, got);
        check("lit_stop_err_seen", 32'(got), 32'h1);
        check("lit_stop_err_count", 32'(err_count), 32'h2);
        tick(Cpb * 2);
        send_frame(8'h03, 8'h48, 8'hEE);
        wait_pulse(1'b0, got);
        check("lit_stop_recover", 32'(temp_f), 32'h072);
        tick(20);

        // Inter-byte timeout.
        send(8'hA5);
        send(8'h03);
        push_err();
        tick(Tmo + 100);
        check("lit_timeout_count", 32'(err_count), 32'h3);
        send_frame(8'h07, 8'h50, 8'hF2);
        wait_pulse(1'b0, got);
        check("lit_to_temp", 32'(temp_f), 32'h080);
        check("lit_to_status", 32'(status), 32'h7);
        tick(20);

        // Randomized frames, some corrupted, some preceded by junk bytes.
        for (int f = 0; f < 30; f++) begin
            r_st = 8'($urandom);
            r_tp = 8'($urandom);
            r_cs = 8'hA5 ^ r_st ^ r_tp;
            case ($urandom_range(0, 3))
                0: r_cs = r_cs ^ 8'($urandom_range(1, 255));
                1: begin
                    send(8'($urandom_range(0, 8'hA4)));
                    tick($urandom_range(0, 10));
                end
                default: ;
            endcase
            send(8'hA5);
            tick($urandom_range(0, 30));
            send(r_st);
            tick($urandom_range(0, 30));
            send(r_tp);
            tick($urandom_range(0, 30));
            send(r_cs);
            tick($urandom_range(15, 40));
        end

        // Reset in the middle of the TEMP byte.
        send(8'hA5);
        send(8'h03);
        rx = 1'b0;
        tick(Cpb * 3);
        rst    = 1'b1;
        rx     = 1'b1;
        pstate = 0;
        tick(4);
        rst = 1'b0;
        check("lit_midrst_temp", 32'(temp_f), 32'h0);
        check("lit_midrst_count", 32'(err_count), 32'h0);
        check("lit_midrst_link", 32'(link_ok), 32'h0);
        tick(Cpb * 12);
        send_frame(8'h03, 8'h48, 8'hEE);
        wait_pulse(1'b0, got);
        check("lit_after_rst_temp", 32'(temp_f), 32'h072);
        check("lit_after_rst_link", 32'(link_ok), 32'h1);
        tick(Stale + 10);
        check("lit_stale_link", 32'(link_ok), 32'h0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            push_err();
            send_byte(8'h00, 1'b0);
            tick(Cpb * 2);
        end
        tick(20);
        check("lit_err_saturate", 32'(err_count), 32'hFF);
        check("pending_events", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
